avalon_read_responder: RTL

//  Avalon-MM read slave (responder) serving the func block's 16-bit pipelined read master.

---
 rtl/avalon_read_responder_if.sv | 29 ++
 rtl/avalon_read_responder.sv | 128 ++++++++++++
 2 files changed

// File: rtl/avalon_read_responder_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// avalon_read_responder_if : Avalon-MM pipelined read bus (32b addr, 16b data)
// Revision: 1.0
// ----------------------------------------------------------------------------
interface avalon_read_responder_if;
  logic [31:0] address;
  logic        read;
  logic        waitrequest;
  logic [15:0] readdata;
  logic        readdatavalid;

  modport master (
    output address,
    output read,
    input  waitrequest,
    input  readdata,
    input  readdatavalid
  );

  modport slave (
    input  address,
    input  read,
    output waitrequest,
    output readdata,
    output readdatavalid
  );
endinterface
`default_nettype wire

// File: rtl/avalon_read_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// avalon_read_responder : Avalon-MM read slave, fixed-latency RAM returns
// Revision: 1.0
// ----------------------------------------------------------------------------
module avalon_read_responder #(
  parameter int AW       = 10,
  parameter int LATENCY  = 3,
  parameter int GAP      = 0,
  parameter int MAX_PEND = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  avalon_read_responder_if.slave bus,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [15:0]           wr_data,
  output logic                  range_err
);

  localparam int         DEPTH      = 2 ** AW;
  localparam logic [3:0] C_GAP      = 4'(GAP);
  localparam logic [3:0] C_MAX_PEND = 4'(MAX_PEND);

  logic [15:0]        mem [DEPTH];

  logic               init_q;
  logic [3:0]         gap_q, gap_d;
  logic [3:0]         pend_q, pend_d;
  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] err_q;
  logic [15:0]        dat_q [LATENCY];
  logic [15:0]        hold_q;
  logic               sticky_q;

  logic               accept;
  logic               addr_err;
  logic               ret_enter;
  logic [AW-1:0]      word_idx;
  logic [15:0]        rd_word;

  // Stall decision uses only registered state, never read/address.
  assign bus.waitrequest = init_q | (gap_q != 4'd0) | (pend_q == C_MAX_PEND);
  assign accept          = bus.read & ~bus.waitrequest;

  assign word_idx = bus.address[AW:1];
  assign addr_err = (bus.address[31:AW+1] != '0) | bus.address[0];
  assign rd_word  = addr_err ? 16'h0000 : mem[word_idx];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // A read stops counting as pending on the edge that raises readdatavalid.
  generate
    if (LATENCY == 1) begin : g_lat_one
      assign ret_enter = accept;
    end else begin : g_lat_multi
      assign ret_enter = vld_q[LATENCY-2];
    end
  endgenerate

  always_comb begin
    gap_d  = gap_q;
    pend_d = pend_q;
    if (accept) begin
      gap_d = C_GAP;
    end else if (gap_q != 4'd0) begin
      gap_d = gap_q - 4'd1;
    end
    case ({accept, ret_enter})
      2'b10:   pend_d = pend_q + 4'd1;
      2'b01:   pend_d = pend_q - 4'd1;
      default: pend_d = pend_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_q <= 1'b1;
      gap_q  <= 4'd0;
      pend_q <= 4'd0;
    end else begin
      init_q <= 1'b0;
      gap_q  <= gap_d;
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        dat_q[i] <= 16'h0000;
      end
    end else begin
      vld_q[0] <= accept;
      err_q[0] <= accept & addr_err;
      if (accept) begin
        dat_q[0] <= rd_word;
      end
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q   <= 16'h0000;
      sticky_q <= 1'b0;
    end else if (vld_q[LATENCY-1]) begin
      hold_q   <= dat_q[LATENCY-1];
      sticky_q <= sticky_q | err_q[LATENCY-1];
    end
  end

  assign bus.readdatavalid = vld_q[LATENCY-1];
  assign bus.readdata      = vld_q[LATENCY-1] ? dat_q[LATENCY-1] : hold_q;
  assign range_err         = sticky_q | (vld_q[LATENCY-1] & err_q[LATENCY-1]);

endmodule
`default_nettype wire
